// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for a multi-digit common-segment
// seven-segment display. One shared BCD-to-segment decoder is fed one stored
// nibble at a time; each refresh slot is a blanking gap followed by the digit
// being shown, scanning digit 0 up to digit NUM_DIGITS-1 and wrapping.
//
// New BCD words are double-buffered (pending -> active) and only take effect
// at a frame boundary, so a displayed frame never mixes two loaded words.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   enable     1 = scanning runs, 0 = display off (blank)
//   load       single-cycle strobe capturing bcd_in
//   bcd_in     packed BCD word, nibble i = digit i
//   lz_en      leading-zero suppression enable (sampled live)
//   digit_bcd  nibble to the shared decoder, 4'hF = blank
//   digit_en   one-hot active-high digit enable, all-zero when blanked
//   frame_done one-cycle pulse after the last slot of each frame
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lz_en,
  output logic [3:0]              digit_bcd,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
  localparam logic [3:0]       BLANK_CODE   = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        index;
  logic [CNT_W-1:0]        count;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pending_valid;
  logic                    frame_end;

  // One-hot enable pattern for the given digit index.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Nibble presented for digit idx: blanked when leading-zero suppression is
  // on, the digit is not digit 0, and it and every more significant nibble
  // are zero.
  function automatic logic [3:0] shown_nibble(input logic [IDX_W-1:0]        idx,
                                              input logic [4*NUM_DIGITS-1:0] word,
                                              input logic                    lz);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx)) && (word[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end else begin
        upper_zero = upper_zero;
      end
    end
    if (lz && (idx != '0) && upper_zero) begin
      return BLANK_CODE;
    end else begin
      return word[4*int'(idx) +: 4];
    end
  endfunction

  // Last cycle of the last digit's show slot while scanning stays enabled.
  assign frame_end = enable && (state == SHOW) && (count == REFRESH_LAST) &&
                     (index == IDX_LAST);

  // Scan sequencer: state, digit index, slot counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      index      <= '0;
      count      <= '0;
      digit_bcd  <= BLANK_CODE;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        index     <= '0;
        count     <= '0;
        digit_bcd <= BLANK_CODE;
        digit_en  <= '0;
      end else begin
        case (state)
          IDLE: begin
            state     <= BLANK;
            index     <= '0;
            count     <= '0;
            digit_bcd <= BLANK_CODE;
            digit_en  <= '0;
          end
          BLANK: begin
            if (count == BLANK_LAST) begin
              // Outputs for the first show cycle are set up on this edge.
              state     <= SHOW;
              count     <= '0;
              digit_en  <= digit_onehot(index);
              digit_bcd <= shown_nibble(index, active, lz_en);
            end else begin
              count     <= count + CNT_W'(1);
              digit_en  <= '0;
              digit_bcd <= BLANK_CODE;
            end
          end
          SHOW: begin
            if (count == REFRESH_LAST) begin
              state     <= BLANK;
              count     <= '0;
              digit_en  <= '0;
              digit_bcd <= BLANK_CODE;
              if (index == IDX_LAST) begin
                index      <= '0;
                frame_done <= 1'b1;
              end else begin
                index <= index + IDX_W'(1);
              end
            end else begin
              // Re-evaluated every cycle so lz_en changes take effect live.
              count     <= count + CNT_W'(1);
              digit_en  <= digit_onehot(index);
              digit_bcd <= shown_nibble(index, active, lz_en);
            end
          end
          default: begin
            state     <= IDLE;
            index     <= '0;
            count     <= '0;
            digit_bcd <= BLANK_CODE;
            digit_en  <= '0;
          end
        endcase
      end
    end
  end

  // Display word double buffer: active changes only while idle or at a frame
  // boundary; a load landing on the boundary itself wins over pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      if ((state == IDLE) && load) begin
        active <= bcd_in;
      end else if (frame_end && load) begin
        active        <= bcd_in;
        pending_valid <= 1'b0;
      end else if (frame_end && pending_valid) begin
        active        <= pending;
        pending_valid <= 1'b0;
      end else if (load) begin
        pending       <= bcd_in;
        pending_valid <= 1'b1;
      end else begin
        active <= active;
      end
    end
  end

endmodule
